// File: rtl/neopixel_pkg.sv
// Shared types and constants for the NeoPixel frame sequencer.
package neopixel_pkg;

  localparam int unsigned NUM_PIXELS_DEFAULT = 5;
  localparam int unsigned BEATS_PER_PIXEL    = 3;

  // Beat k of a pixel carries colour k, so the encoding doubles as the beat offset.
  typedef enum logic [1:0] {
    COLOR_RED   = 2'b00,
    COLOR_BLUE  = 2'b01,
    COLOR_GREEN = 2'b10
  } color_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StArm,
    StSend,
    StDrain
  } seq_state_t;

endpackage

// File: rtl/neopixel_frame_sequencer_if.sv
// Load/send handshake between the frame sequencer (master) and the strand controller (slave).
interface neopixel_frame_sequencer_if;
  logic       load_color;
  logic       send_it;
  logic [2:0] pixel_index;
  logic [1:0] color_index;
  logic [7:0] color_level;
  logic       ready_to_load;
  logic       ready_to_send;

  modport master (
    output load_color, send_it, pixel_index, color_index, color_level,
    input  ready_to_load, ready_to_send
  );

  modport slave (
    input  load_color, send_it, pixel_index, color_index, color_level,
    output ready_to_load, ready_to_send
  );
endinterface

// File: rtl/neopixel_level_scaler.sv
// Combinational colour-level scale: (level * (brightness + 1)) >> 8.
module neopixel_level_scaler
  import neopixel_pkg::*;
(
  input  logic [7:0] i_level,
  input  logic [7:0] i_brightness,
  output logic [7:0] o_level
);

  assign o_level = 8'((16'(i_level) * (16'(i_brightness) + 16'd1)) >> 8);

endmodule

// File: rtl/neopixel_frame_sequencer.sv
// Snapshots a host-written shadow frame and replays it into the strand controller.
// Optional global brightness scaling is enabled with `define NEOPIXEL_BRIGHTNESS_EN.
module neopixel_frame_sequencer
  import neopixel_pkg::*;
#(
  parameter int unsigned NUM_PIXELS = NUM_PIXELS_DEFAULT
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_wr_en,
  input  logic [2:0] i_wr_pixel,
  input  logic [1:0] i_wr_color,
  input  logic [7:0] i_wr_level,
  input  logic       i_frame_go,
  input  logic [7:0] i_brightness,
  neopixel_frame_sequencer_if.master io_ctrl,
  output logic       o_busy,
  output logic       o_frame_done
);

  localparam int unsigned Beats = NUM_PIXELS * BEATS_PER_PIXEL;
  localparam int unsigned BeatW = $clog2(Beats);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);
  localparam logic [BeatW-1:0] BeatsPerPixel = BeatW'(BEATS_PER_PIXEL);

  seq_state_t     r_state, w_state_next;
  logic [BeatW-1:0] r_beat;
  logic           r_pending;
  logic [7:0]     r_shadow [Beats];
  logic [7:0]     r_work   [Beats];
  logic [7:0]     w_shadow_next [Beats];

  logic             w_wr_valid;
  logic [BeatW-1:0] w_wr_addr;
  logic             w_start, w_load, w_send, w_done, w_accept;
  logic [2:0]       w_pixel;
  color_t           w_color;
  logic [7:0]       w_raw_level, w_level;

  assign w_wr_valid = i_wr_en && (32'(i_wr_pixel) < NUM_PIXELS) && (i_wr_color != 2'b11);
  assign w_wr_addr  = BeatW'(32'(i_wr_pixel) * BEATS_PER_PIXEL + 32'(i_wr_color));

  // Same-cycle write is folded in here so a frame start copies it too.
  always_comb begin
    w_shadow_next = r_shadow;
    if (w_wr_valid) begin
      w_shadow_next[w_wr_addr] = i_wr_level;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_load       = 1'b0;
    w_send       = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_frame_go || r_pending) begin
          w_start      = 1'b1;
          w_state_next = StLoad;
        end
      end
      StLoad: begin
        w_load = 1'b1;
        if (io_ctrl.ready_to_load && (r_beat == LastBeat)) begin
          w_state_next = StArm;
        end
      end
      StArm: begin
        if (io_ctrl.ready_to_send) begin
          w_state_next = StSend;
        end
      end
      StSend: begin
        w_send       = 1'b1;
        w_state_next = StDrain;
      end
      StDrain: begin
        if (io_ctrl.ready_to_load) begin
          w_done       = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign w_accept = w_load && io_ctrl.ready_to_load;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_beat    <= '0;
      r_pending <= 1'b0;
      for (int i = 0; i < int'(Beats); i++) begin
        r_shadow[i] <= '0;
        r_work[i]   <= '0;
      end
    end else begin
      r_state  <= w_state_next;
      r_shadow <= w_shadow_next;
      if (w_start) begin
        r_work <= w_shadow_next;
        r_beat <= '0;
      end else if (w_accept && (r_beat != LastBeat)) begin
        r_beat <= r_beat + 1'b1;
      end
      // Idle always consumes the flag; a busy-time request is held one-deep.
      if (r_state == StIdle) begin
        r_pending <= 1'b0;
      end else if (i_frame_go) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign w_pixel     = 3'(r_beat / BeatsPerPixel);
  assign w_color     = color_t'(2'(r_beat % BeatsPerPixel));
  assign w_raw_level = r_work[r_beat];

`ifdef NEOPIXEL_BRIGHTNESS_EN
  logic [7:0] r_brightness;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_brightness <= '0;
    end else if (w_start) begin
      r_brightness <= i_brightness;
    end
  end

  neopixel_level_scaler u_scaler (
    .i_level      (w_raw_level),
    .i_brightness (r_brightness),
    .o_level      (w_level)
  );
`else
  logic w_unused_brightness;
  assign w_unused_brightness = ^i_brightness;
  assign w_level = w_raw_level;
`endif

  // Beat fields are forced to zero outside LOAD so idle/arm/drain present a quiet bus.
  assign io_ctrl.load_color  = w_load;
  assign io_ctrl.send_it     = w_send;
  assign io_ctrl.pixel_index = w_load ? w_pixel : 3'd0;
  assign io_ctrl.color_index = w_load ? w_color : COLOR_RED;
  assign io_ctrl.color_level = w_load ? w_level : 8'd0;
  assign o_busy              = (r_state != StIdle);
  assign o_frame_done        = w_done;

endmodule

// File: tb/tb_neopixel_frame_sequencer.sv
// Randomised bench for neopixel_frame_sequencer against a frame-level reference model.
module tb_neopixel_frame_sequencer;
  import neopixel_pkg::*;

  localparam int NP = 5;
  localparam int NB = NP * 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_pixel = '0;
  logic [1:0] wr_color = '0;
  logic [7:0] wr_level = '0;
  logic       frame_go = 1'b0;
  logic [7:0] brightness = 8'hFF;
  logic       busy, frame_done;

  neopixel_frame_sequencer_if ctrl ();

  neopixel_frame_sequencer #(.NUM_PIXELS(NP)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_wr_en      (wr_en),
    .i_wr_pixel   (wr_pixel),
    .i_wr_color   (wr_color),
    .i_wr_level   (wr_level),
    .i_frame_go   (frame_go),
    .i_brightness (brightness),
    .io_ctrl      (ctrl),
    .o_busy       (busy),
    .o_frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 loading, 2 waiting to send, 3 send pulse, 4 draining.
  int         m_phase;
  int         m_beat;
  bit         m_pend;
  logic [7:0] m_bright;
  logic [7:0] m_shadow [NB];
  logic [7:0] m_frame  [NB];
  logic [7:0] act_level [NB];
  int         n_accept = 0, n_send = 0, n_done = 0, n_start = 0;
  bit         toggle_rtl = 1'b0;

  function automatic logic [7:0] scale(input logic [7:0] lv, input logic [7:0] b);
`ifdef NEOPIXEL_BRIGHTNESS_EN
    return 8'((int'(lv) * (int'(b) + 1)) / 256);
`else
    return lv;
`endif
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_beat   = 0;
    m_pend   = 1'b0;
    m_bright = '0;
    for (int i = 0; i < NB; i++) begin
      m_shadow[i] = '0;
      m_frame[i]  = '0;
    end
  endtask

  task automatic model_step();
    logic [7:0] nxt [NB];
    bit         e_load;
    int         old_phase;
    e_load = (m_phase == 1);
    check("busy", busy, 32'(m_phase != 0));
    check("load_color", ctrl.load_color, 32'(e_load));
    check("send_it", ctrl.send_it, 32'(m_phase == 3));
    check("frame_done", frame_done, 32'(m_phase == 4 && ctrl.ready_to_load));
    check("pixel_index", ctrl.pixel_index, e_load ? 32'(m_beat / 3) : 32'd0);
    check("color_index", ctrl.color_index, e_load ? 32'(m_beat % 3) : 32'd0);
    check("color_level", ctrl.color_level, e_load ? 32'(scale(m_frame[m_beat], m_bright)) : 32'd0);
    if (ctrl.load_color && ctrl.ready_to_load) begin
      if (n_accept < NB) act_level[n_accept] = ctrl.color_level;
      n_accept++;
    end
    if (ctrl.send_it) n_send++;
    if (frame_done) n_done++;
    if (rst) begin
      model_reset();
    end else begin
      nxt = m_shadow;
      if (wr_en && int'(wr_pixel) < NP && wr_color != 2'b11)
        nxt[int'(wr_pixel) * 3 + int'(wr_color)] = wr_level;
      old_phase = m_phase;
      case (m_phase)
        0: if (frame_go || m_pend) begin
          m_frame  = nxt;
          m_beat   = 0;
          m_bright = brightness;
          m_phase  = 1;
          n_start++;
          n_accept = 0;
        end
        1: if (ctrl.ready_to_load) begin
          if (m_beat == NB - 1) m_phase = 2;
          else m_beat++;
        end
        2: if (ctrl.ready_to_send) m_phase = 3;
        3: m_phase = 4;
        default: if (ctrl.ready_to_load) m_phase = 0;
      endcase
      if (old_phase == 0) m_pend = 1'b0;
      else if (frame_go) m_pend = 1'b1;
      m_shadow = nxt;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    if (toggle_rtl) ctrl.ready_to_load = ~ctrl.ready_to_load;
  endtask

  task automatic write(input int p, input int c, input logic [7:0] l);
    wr_en    = 1'b1;
    wr_pixel = 3'(p);
    wr_color = 2'(c);
    wr_level = l;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic go();
    frame_go = 1'b1;
    tick();
    frame_go = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0, k;
    d0 = n_done;
    k  = 0;
    while (n_done == d0 && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(n_done - d0), 32'd1);
  endtask

  task automatic wait_accepts(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (n_accept < target && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(n_accept), 32'(target));
  endtask

  function automatic logic [7:0] or_levels();
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < NB; i++) acc |= act_level[i];
    return acc;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, st0;
    logic [7:0] first_beat0;
    ctrl.ready_to_load = 1'b1;
    ctrl.ready_to_send = 1'b1;
    model_reset();
    for (int i = 0; i < NB; i++) act_level[i] = '0;

    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_load", ctrl.load_color, 0);
    check("rst_level", ctrl.color_level, 0);
    rst = 1'b0;
    tick();

    // Basic frame.
    write(4, 0, 8'hFF);
    write(0, 1, 8'h73);
    write(2, 2, 8'hB3);
    s0 = n_send;
    go();
    check("start_busy", busy, 1);
    check("start_load", ctrl.load_color, 1);
    wait_done("basic_done", 60);
    check("basic_accepts", 32'(n_accept), 32'd15);
    check("basic_sends", 32'(n_send - s0), 32'd1);
    check("basic_beat0", act_level[0], 8'h00);
    check("basic_beat1", act_level[1], 8'h73);
    check("basic_beat8", act_level[8], 8'hB3);
    check("basic_beat12", act_level[12], 8'hFF);

    // Invalid writes leave the shadow frame zero.
    do_reset();
    write(0, 3, 8'hD4);
    write(6, 0, 8'h5A);
    go();
    wait_done("invalid_done", 60);
    check("invalid_accepts", 32'(n_accept), 32'd15);
    check("invalid_levels", or_levels(), 8'h00);

    // Load stalls and a held-off send.
    write(1, 1, 8'h3C);
    write(3, 2, 8'hC5);
    ctrl.ready_to_send = 1'b0;
    s0 = n_send;
    toggle_rtl = 1'b1;
    go();
    wait_accepts("stall_accepts", 15, 100);
    for (int i = 0; i < 10; i++) tick();
    check("arm_hold_send", 32'(n_send - s0), 32'd0);
    check("arm_hold_busy", busy, 1);
    ctrl.ready_to_send = 1'b1;
    toggle_rtl = 1'b0;
    ctrl.ready_to_load = 1'b1;
    wait_done("stall_done", 60);
    check("stall_sends", 32'(n_send - s0), 32'd1);
    check("stall_accepts_total", 32'(n_accept), 32'd15);
    check("stall_beat4", act_level[4], 8'h3C);
    check("stall_beat11", act_level[11], 8'hC5);

    // Overlapping requests and a write during load.
    write(0, 0, 8'h11);
    st0 = n_start;
    go();
    for (int i = 0; i < 14; i++) begin
      frame_go = (i == 2 || i == 5 || i == 12);
      wr_en    = (i == 3);
      wr_pixel = 3'd0;
      wr_color = 2'd0;
      wr_level = 8'h50;
      tick();
    end
    frame_go = 1'b0;
    wr_en    = 1'b0;
    wait_done("ovl_first_done", 60);
    first_beat0 = act_level[0];
    check("ovl_first_beat0", first_beat0, 8'h11);
    wait_done("ovl_second_done", 60);
    check("ovl_second_beat0", act_level[0], 8'h50);
    for (int i = 0; i < 20; i++) tick();
    check("ovl_frames", 32'(n_start - st0), 32'd2);

    // Reset in the middle of loading.
    write(0, 0, 8'hAA);
    write(3, 1, 8'hCC);
    go();
    wait_accepts("mid_accepts", 7, 40);
    s0 = n_send;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_busy", busy, 0);
    check("mid_load", ctrl.load_color, 0);
    check("mid_send", ctrl.send_it, 0);
    check("mid_done", frame_done, 0);
    check("mid_pixel", ctrl.pixel_index, 0);
    check("mid_color", ctrl.color_index, 0);
    check("mid_level", ctrl.color_level, 0);
    for (int i = 0; i < 5; i++) tick();
    check("mid_no_send", 32'(n_send - s0), 32'd0);
    go();
    wait_done("mid_replay_done", 60);
    check("mid_replay_accepts", 32'(n_accept), 32'd15);
    check("mid_replay_levels", or_levels(), 8'h00);

    // Random traffic checked cycle by cycle by the model.
    for (int i = 0; i < 500; i++) begin
      ctrl.ready_to_load = ($urandom_range(0, 3) != 0);
      ctrl.ready_to_send = ($urandom_range(0, 3) != 0);
      wr_en      = $urandom_range(0, 1) == 1;
      wr_pixel   = 3'($urandom_range(0, 7));
      wr_color   = 2'($urandom_range(0, 3));
      wr_level   = 8'($urandom);
      frame_go   = ($urandom_range(0, 15) == 0);
      brightness = 8'($urandom);
      tick();
    end
    ctrl.ready_to_load = 1'b1;
    ctrl.ready_to_send = 1'b1;
    wr_en      = 1'b0;
    frame_go   = 1'b0;
    brightness = 8'hFF;
    for (int i = 0; i < 80; i++) tick();
    check("rand_idle", busy, 0);

`ifdef NEOPIXEL_BRIGHTNESS_EN
    do_reset();
    write(0, 0, 8'hFF);
    brightness = 8'h7F;
    go();
    wait_done("bright7f_done", 60);
    check("bright7f_level", act_level[0], 8'h7F);
    brightness = 8'h00;
    go();
    wait_done("bright00_done", 60);
    check("bright00_level", act_level[0], 8'h00);
    brightness = 8'hFF;
    go();
    wait_done("brightff_done", 60);
    check("brightff_level", act_level[0], 8'hFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/neopixel_frame_sequencer.md
# neopixel_frame_sequencer

Upstream feeder for `NeoPixelStrandController`. It holds a host-writable shadow frame buffer of NUM_PIXELS×3 colour levels. On a frame request it snapshots the buffer and replays it into the controller's load interface, one `load_color` beat per colour. It then issues `send_it` and waits for the strand transmission to finish, so host logic never sequences the controller handshakes itself.

## Interface
- NUM_PIXELS, 5, pixels on the strand; must match the controller (5 × 24 b = 120 b packet).
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  host write strobe into the shadow buffer.
- wr_pixel  in  3  pixel for the write; values ≥ NUM_PIXELS are ignored.
- wr_color  in  2  colour for the write: 00 red, 01 blue, 10 green; 11 is ignored.
- wr_level  in  8  colour level to write.
- frame_go  in  1  request to commit and transmit the current shadow frame.
- brightness  in  8  global brightness; used only when the macro is defined.
- ready_to_load  in  1  from the controller: accepts a `load_color` beat this cycle.
- ready_to_send  in  1  from the controller: accepts `send_it` this cycle.
- load_color  out  1  load beat to the controller.
- send_it  out  1  one-cycle transmit pulse to the controller.
- pixel_index  out  3  pixel for the current load beat.
- color_index  out  2  colour for the current load beat; never 11.
- color_level  out  8  level for the current load beat.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when a frame's transmission has completed.

## Operation
- **Shadow writes**
  - A shadow write occurs when `wr_en` is high and both `wr_pixel` and `wr_color` are valid.
  - Shadow writes are accepted in every state, including while `busy` is high.
  - Writes while busy affect only the next frame, never the frame in flight.
- **States:** IDLE, LOAD, ARM, SEND, DRAIN.
- **IDLE**
  - Leaves IDLE on `frame_go` or a pending request.
  - On leaving, copies the shadow buffer into the working buffer.
  - A shadow write in the same cycle as `frame_go` is included in the copy (bypass).
  - Resets the beat counter to 0 and goes to LOAD.
- **LOAD**
  - Beat k maps to pixel = k/3 and colour = k%3, with colour order red (00), blue (01), green (10).
  - `load_color` is held high with the beat's index and level.
  - The beat counter advances only on a cycle where `load_color && ready_to_load`.
  - After beat 3·NUM_PIXELS−1 is accepted, go to ARM.
- **ARM**
  - `load_color` is low.
  - When `ready_to_send` is high, go to SEND.
- **SEND**
  - `send_it` is high for exactly one cycle; then go to DRAIN.
- **DRAIN**
  - Waits until `ready_to_load` is high, with a minimum of one cycle in DRAIN.
  - Then pulses `frame_done` and goes to IDLE.
- **Pending request**
  - `frame_go` while busy sets a one-deep pending flag; further requests are absorbed.
  - The pending flag clears when IDLE consumes it, so the next frame starts the cycle after `frame_done`.
- **Data path**
  - Index outputs are driven combinationally from the beat counter.
  - The level is read from the working buffer.

## Timing
- **Reset values**
  - All outputs are 0: `load_color`, `send_it`, `busy`, `frame_done`, `pixel_index`, `color_index`, `color_level`.
  - State is IDLE.
  - The shadow and working buffers are all 0.
  - The pending flag is cleared.
- **Reset mid-frame:** the same values apply on the next edge, with no `send_it` or `frame_done` emitted.
- **Start latency:** `frame_go` sampled at edge t gives `busy` and `load_color` high after edge t.
- **Minimum frame:** with `ready_to_load` and `ready_to_send` constantly high, there are 15 load cycles, 1 ARM cycle, then `send_it`.
- **Stalls:** `ready_to_load` low in LOAD stalls the beat with its outputs held stable.
- **`frame_done`:** never coincides with `load_color` or `send_it`.

## Configuration
- **`NEOPIXEL_BRIGHTNESS_EN` defined**
  - `brightness` is sampled into a register at the IDLE→LOAD transition.
  - Output level is (level × (brightness+1)) >> 8, computed at 16 b and truncated to 8 b.
  - brightness 255 passes levels unchanged; brightness 0 yields 0 for all levels.
- **Macro undefined:** `color_level` equals the working-buffer level, and `brightness` is ignored.

## Structure
- Package `neopixel_pkg` contains:
  - `color_t` enum: COLOR_RED=2'b00, COLOR_BLUE=2'b01, COLOR_GREEN=2'b10.
  - NUM_PIXELS_DEFAULT=5.
  - BEATS_PER_PIXEL=3.
  - `seq_state_t` for IDLE/LOAD/ARM/SEND/DRAIN.
- Sub-module `neopixel_level_scaler`:
  - Combinational level×brightness scale.
  - Instantiated only under `NEOPIXEL_BRIGHTNESS_EN`.

## Test plan
- **Basic frame:** write pixel4/red=FF, pixel0/blue=73, pixel2/green=B3, then `frame_go`, with ready signals high.
  - 15 beats in order (p0 R,B,G … p4 R,B,G).
  - Beat 1 carries 73, beat 8 carries B3, beat 12 carries FF.
  - `send_it` one cycle after the last beat; `frame_done` once `ready_to_load` returns.
- **Invalid writes:** `wr_color`=11 with level D4, and `wr_pixel`=6.
  - Shadow buffer unchanged; all 15 beats carry 00.
- **Stalls:** toggle `ready_to_load` every other cycle in LOAD.
  - Each beat's index and level stay stable until accepted; exactly 15 acceptances.
  - Hold `ready_to_send` low for 10 cycles in ARM: `send_it` is delayed, still a single pulse.
- **Overlap:** `frame_go` pulsed three times during a frame, plus a shadow write of pixel0/red=50 during LOAD.
  - The current frame is unaffected.
  - Exactly one follow-on frame starts the cycle after `frame_done`, and its beat 0 carries 50.
- **Reset mid-LOAD at beat 7:** all outputs 0 next cycle; no `send_it`; a new `frame_go` replays from beat 0 with zeroed buffers.
- **Brightness (macro defined):** brightness=7F with level FF.
  - Beat carries 7F.
  - brightness=00 gives 00; brightness=FF gives FF.
